data_memory_lsu: RTL

- Next-generation data memory for the pipelined core's MEM stage: word-organised, byte-lane RAM with a load/store-aware port A for the pipeline and a valid/ready port B for AXI-side access.
- Port A takes byte addresses plus RISC-V access size and signedness, then performs lane shifting, sign or zero extension and misalignment detection internally.
- Port B is a handshaked word port with a response FSM and write-collision stalling.
- Single clock domain.

---
 rtl/data_memory_lsu.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: word-organised byte-lane data memory for the MEM stage.
//   Port A (pipeline): byte address + RISC-V size/signedness. Stores are
//     lane-shifted into the word. Loads return one cycle later,
//     shifted to bit 0 and extended. Misaligned/illegal accesses are dropped
//     and flagged one cycle later on a_misalign.
//   Port B (AXI side): valid/ready word port with byte strobes. A two-state
//     response FSM (IDLE/RESP) holds b_rdata until b_rsp_ready.
// Ports: clk, reset (sync, active-high); a_req/a_we/a_addr/a_size/a_unsigned/
//   a_wdata -> a_rdata/a_rvalid/a_misalign; b_req_valid/b_we/b_addr/b_wstrb/
//   b_wdata -> b_req_ready; b_rsp_valid/b_rdata <- b_rsp_ready.
module data_memory_lsu #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 256,
  parameter int RD_MODE    = 0,
  localparam int NB = DATA_WIDTH / 8,
  localparam int AW = $clog2(DEPTH * NB),
  localparam int WW = $clog2(DEPTH),
  localparam int LB = $clog2(NB)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [AW-1:0]         a_addr,
  input  logic [1:0]            a_size,
  input  logic                  a_unsigned,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic [DATA_WIDTH-1:0] a_rdata,
  output logic                  a_rvalid,
  output logic                  a_misalign,
  input  logic                  b_req_valid,
  output logic                  b_req_ready,
  input  logic                  b_we,
  input  logic [WW-1:0]         b_addr,
  input  logic [NB-1:0]         b_wstrb,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_rsp_valid,
  input  logic                  b_rsp_ready,
  output logic [DATA_WIDTH-1:0] b_rdata
);

  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_nxt;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // ---------------- port A decode ----------------
  logic [WW-1:0]         a_word;
  logic [LB-1:0]         a_off;
  logic [2:0]            a_amask;
  logic [7:0]            a_be_raw;
  logic [NB-1:0]         a_be;
  logic [DATA_WIDTH-1:0] a_wsh;
  logic                  a_bad, a_ld, a_st;

  assign a_word = a_addr[AW-1:LB];
  assign a_off  = a_addr[LB-1:0];

  always_comb begin
    a_amask  = 3'd0;
    a_be_raw = 8'h01;
    case (a_size)
      2'd0: begin a_amask = 3'd0; a_be_raw = 8'h01; end
      2'd1: begin a_amask = 3'd1; a_be_raw = 8'h03; end
      2'd2: begin a_amask = 3'd3; a_be_raw = 8'h0F; end
      default: begin a_amask = 3'd7; a_be_raw = 8'hFF; end
    endcase
  end

  assign a_bad = ((a_addr[2:0] & a_amask) != 3'd0) ||
                 ((a_size == 2'd3) && (DATA_WIDTH == 32));
  assign a_ld  = a_req && !a_we && !a_bad;
  assign a_st  = a_req &&  a_we && !a_bad;
  assign a_be  = a_be_raw[NB-1:0] << a_off;
  assign a_wsh = a_wdata << {a_off, 3'b000};

  // ---------------- port B decode ----------------
  logic                  collide, b_acc;
  logic [DATA_WIDTH-1:0] b_old, b_merged;

  // Only a same-word write/write pair can conflict; B yields to the pipeline.
  assign collide = a_st && b_we && (a_word == b_addr);
  assign b_acc   = b_req_valid && b_req_ready;
  assign b_old   = mem[b_addr];

  always_comb begin
    b_merged = b_old;
    for (int i = 0; i < NB; i++)
      if (b_wstrb[i]) b_merged[8*i +: 8] = b_wdata[8*i +: 8];
  end

  // ---------------- storage (never reset) ----------------
  always_ff @(posedge clk) begin
    if (a_st)
      for (int i = 0; i < NB; i++)
        if (a_be[i]) mem[a_word][8*i +: 8] <= a_wsh[8*i +: 8];
    if (b_acc && b_we)
      for (int i = 0; i < NB; i++)
        if (b_wstrb[i]) mem[b_addr][8*i +: 8] <= b_wdata[8*i +: 8];
  end

  // ---------------- port A load pipeline ----------------
  logic [DATA_WIDTH-1:0] a_q_word;
  logic [LB-1:0]         a_q_off;
  logic [1:0]            a_q_size;
  logic                  a_q_uns;

  // Nonblocking read sees pre-edge contents: old data on a same-cycle B write.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_rvalid   <= 1'b0;
      a_misalign <= 1'b0;
      a_q_word   <= '0;
      a_q_off    <= '0;
      a_q_size   <= '0;
      a_q_uns    <= 1'b0;
    end else begin
      a_rvalid   <= a_ld;
      a_misalign <= a_req && a_bad;
      if (a_ld) begin
        a_q_word <= mem[a_word];
        a_q_off  <= a_off;
        a_q_size <= a_size;
        a_q_uns  <= a_unsigned;
      end
    end
  end

  logic [DATA_WIDTH-1:0] a_shift, a_mask;
  logic                  a_sgn;

  always_comb begin
    a_shift = a_q_word >> {a_q_off, 3'b000};
    a_mask  = '1;
    a_sgn   = 1'b0;
    case (a_q_size)
      2'd0: begin a_mask = DATA_WIDTH'(8'hFF);         a_sgn = a_shift[7];  end
      2'd1: begin a_mask = DATA_WIDTH'(16'hFFFF);      a_sgn = a_shift[15]; end
      2'd2: begin a_mask = DATA_WIDTH'(32'hFFFF_FFFF); a_sgn = a_shift[31]; end
      default: begin a_mask = '1; a_sgn = 1'b0; end
    endcase
    a_rdata = '0;
    if (a_rvalid)
      a_rdata = (a_shift & a_mask) | ({DATA_WIDTH{a_sgn & ~a_q_uns}} & ~a_mask);
  end

  // ---------------- port B response FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    b_req_ready = 1'b0;
    b_rsp_valid = 1'b0;
    case (state)
      IDLE: begin
        b_req_ready = !collide && !reset;
        if (b_req_valid && !collide && !reset) state_nxt = RESP;
      end
      RESP: begin
        b_rsp_valid = !reset;
        if (b_rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset)      b_rdata <= '0;
    else if (b_acc) b_rdata <= (RD_MODE != 0 && b_we) ? b_merged : b_old;
  end

endmodule
